// File: rtl/wb_responder_pkg.sv
// +-----------------------------------------------------------------------------
// | wb_responder_pkg : Wishbone B3 cycle/burst type codes and responder states
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package wb_responder_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_burst_addr_gen.sv
// +-----------------------------------------------------------------------------
// | wb_burst_addr_gen : next word address of a Wishbone incrementing burst
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module wb_burst_addr_gen
  import wb_responder_pkg::*;
#(
  parameter int WW = 30
) (
  input  logic [WW-1:0] word,
  input  logic [1:0]    bte,
  output logic [WW-1:0] next_word
);

  logic [WW-1:0] w_mask;
  logic [WW-1:0] w_inc;

  // Bits under the mask advance; bits outside stay fixed, giving wrap-N.
  always_comb begin
    w_mask = '1;
    case (bte)
      BTE_LINEAR: w_mask = '1;
      BTE_WRAP4:  w_mask = WW'(3);
      BTE_WRAP8:  w_mask = WW'(7);
      BTE_WRAP16: w_mask = WW'(15);
      default:    w_mask = '1;
    endcase
  end

  assign w_inc     = word + WW'(1);
  assign next_word = (word & ~w_mask) | (w_inc & w_mask);

endmodule

`default_nettype wire

// File: rtl/wb_mem_responder.sv
// +-----------------------------------------------------------------------------
// | wb_mem_responder : Wishbone B3 memory slave with wait states and bursts.
// | Optional: WB_MEM_RESPONDER_ERR_EN (err on out-of-range word index).
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module wb_mem_responder
  import wb_responder_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  output logic [15:0]     beat_cnt_o
);

  localparam int LB = $clog2(DW / 8);
  localparam int WW = AW - LB;
  localparam int MW = $clog2(MEM_WORDS);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [WW-1:0] r_word, w_word_nxt, w_word_inc;
  logic [2:0]    r_cti, w_cti_nxt;
  logic [1:0]    r_bte, w_bte_nxt;
  logic [15:0]   r_beat_cnt;
  logic [DW-1:0] r_mem [MEM_WORDS];

  logic          w_active;
  logic          w_beat;
  logic          w_oor;
  logic          w_ack;
  logic          w_err;
  logic [MW-1:0] w_idx;
  logic          w_unused_adr;

  assign w_active     = wb_cyc_i & wb_stb_i;
  assign w_idx        = r_word[MW-1:0];
  assign w_unused_adr = ^wb_adr_i[LB-1:0];

`ifdef WB_MEM_RESPONDER_ERR_EN
  assign w_oor = (r_word >= WW'(MEM_WORDS));
`else
  assign w_oor = 1'b0;
`endif

  // A beat terminates only while the master still requests it; a classic
  // cti during a burst ends it without a further beat.
  assign w_beat = w_active & ((r_state == ST_ACK) |
                              ((r_state == ST_BURST) & (wb_cti_i != CTI_CLASSIC)));
  assign w_ack  = w_beat & ~w_oor;
  assign w_err  = w_beat & w_oor;

  wb_burst_addr_gen #(
    .WW(WW)
  ) u_addr_gen (
    .word      (r_word),
    .bte       (r_bte),
    .next_word (w_word_inc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_cti_nxt   = r_cti;
    w_bte_nxt   = r_bte;
    case (r_state)
      ST_IDLE: begin
        if (w_active) begin
          w_word_nxt = wb_adr_i[AW-1:LB];
          w_cti_nxt  = wb_cti_i;
          w_bte_nxt  = wb_bte_i;
          if (WAIT_STATES == 0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_cnt_nxt   = 4'(WAIT_STATES);
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (!w_active) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (w_ack && (r_cti == CTI_INC) && (WAIT_STATES == 0)) begin
          w_word_nxt  = w_word_inc;
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (w_ack && (wb_cti_i != CTI_EOB)) begin
          w_word_nxt = w_word_inc;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_word     <= '0;
      r_cti      <= CTI_CLASSIC;
      r_bte      <= BTE_LINEAR;
      r_beat_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_cti   <= w_cti_nxt;
      r_bte   <= w_bte_nxt;
      if (w_ack || w_err) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  // Contents survive reset; a write in flight when reset is sampled is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_ack && wb_we_i) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wb_sel_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wb_dat_o   = w_ack ? r_mem[w_idx] : '0;
  assign wb_ack_o   = w_ack;
  assign wb_err_o   = w_err;
  assign wb_rty_o   = 1'b0;
  assign beat_cnt_o = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
// +-----------------------------------------------------------------------------
// | tb_wb_mem_responder : directed bench, zero-wait and three-wait responders
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_wb_mem_responder;
  import wb_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic [2:0]  cti = CTI_CLASSIC;
  logic [1:0]  bte = BTE_LINEAR;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, rty0, rty1;
  logic [15:0] cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_mem_responder #(.DW(32), .AW(32), .MEM_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0), .beat_cnt_o(cnt0)
  );

  wb_mem_responder #(.DW(32), .AW(32), .MEM_WORDS(256), .WAIT_STATES(3)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1), .beat_cnt_o(cnt1)
  );

  task automatic set_req(input int d, input logic v);
    if (d == 0) begin cyc0 = v; stb0 = v; end
    else        begin cyc1 = v; stb1 = v; end
  endtask

  // Classic single transfer; lat counts cycles from request to first ack/err (-1 on timeout).
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output int lat, output logic e);
    logic a_s, e_s;
    logic [31:0] q_s;
    lat = -1; rd = '0; e = 1'b0;
    @(posedge clk); #1;
    adr = a; dat_w = wd; sel = s; we = w; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    set_req(d, 1'b1);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      a_s = (d == 0) ? ack0 : ack1;
      e_s = (d == 0) ? err0 : err1;
      q_s = (d == 0) ? dat0 : dat1;
      if (a_s || e_s) begin
        lat = k; rd = q_s; e = e_s;
        break;
      end
    end
    @(posedge clk); #1;
    set_req(d, 1'b0);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got %b want 0", err0); end
    checks++; if (dat0 !== 32'h0) begin failures++; $display("FAIL reset_dat0 got %h want 0", dat0); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
    checks++; if (cnt1 !== 16'd0) begin failures++; $display("FAIL reset_cnt1 got %0d want 0", cnt1); end
    checks++; if (rty0 !== 1'b0 || rty1 !== 1'b0) begin failures++; $display("FAIL reset_rty got %b%b want 00", rty0, rty1); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; int lat; logic e;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, e);
    checks++; if (lat !== 1) begin failures++; $display("FAIL wr_latency got %0d want 1", lat); end
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL ack_drop got %b want 0", ack0); end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, e);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rd_latency got %0d want 1", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got %h want deadbeef", rd); end
    checks++; if (cnt0 !== 16'd2) begin failures++; $display("FAIL wr_rd_cnt got %0d want 2", cnt0); end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; int lat; logic e; logic seen;
    xfer(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd, lat, e);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ws_wr_latency got %0d want 4", lat); end
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, lat, e);
    checks++; if (lat !== 4) begin failures++; $display("FAIL ws_rd_latency got %0d want 4", lat); end
    checks++; if (rd !== 32'h0BADF00D) begin failures++; $display("FAIL ws_rd_data got %h want 0badf00d", rd); end
    // Abandon a read after two cycles of strobe.
    @(posedge clk); #1;
    adr = 32'h20; we = 1'b0; cti = CTI_CLASSIC; set_req(1, 1'b1);
    seen = 1'b0;
    @(negedge clk); seen |= ack1 | err1;
    @(posedge clk); #1;
    @(negedge clk); seen |= ack1 | err1;
    @(posedge clk); #1; set_req(1, 1'b0);
    repeat (6) begin @(negedge clk); seen |= ack1 | err1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ws_abort_ack got %b want 0", seen); end
    checks++; if (cnt1 !== 16'd2) begin failures++; $display("FAIL ws_abort_cnt got %0d want 2", cnt1); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; int lat; logic e;
    xfer(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, rd, lat, e);
    xfer(0, 1'b1, 32'h40, 32'h11223344, 4'b0101, rd, lat, e);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, e);
    checks++; if (rd !== 32'hAA22CC44) begin failures++; $display("FAIL byte_lanes got %h want aa22cc44", rd); end
    checks++; if (cnt0 !== 16'd5) begin failures++; $display("FAIL byte_lanes_cnt got %0d want 5", cnt0); end
  endtask

  task automatic test_wrap_burst;
    logic [31:0] rd; int lat; logic e;
    logic [31:0] ba [4];
    logic [31:0] bd [4];
    ba[0] = 32'h38; ba[1] = 32'h3C; ba[2] = 32'h30; ba[3] = 32'h34;
    bd[0] = 32'h38383838; bd[1] = 32'h3C3C3C3C; bd[2] = 32'h30303030; bd[3] = 32'h34343434;
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, ba[i], bd[i], 4'hF, rd, lat, e);
    @(posedge clk); #1;
    adr = 32'h38; we = 1'b0; cti = CTI_INC; bte = BTE_WRAP4; set_req(0, 1'b1);
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL burst_req_ack got %b want 0", ack0); end
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      adr = ba[b]; cti = (b == 3) ? CTI_EOB : CTI_INC;
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b1 || dat0 !== bd[b]) begin
        failures++; $display("FAIL burst_beat%0d got ack=%b dat=%h want ack=1 dat=%h", b, ack0, dat0, bd[b]);
      end
    end
    // A fresh classic request right after EOB must not be acked in the same cycle.
    @(posedge clk); #1;
    adr = 32'h10; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL burst_end_ack got %b want 0", ack0); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b1 || dat0 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL post_burst got ack=%b dat=%h want ack=1 dat=deadbeef", ack0, dat0);
    end
    @(posedge clk); #1; set_req(0, 1'b0);
    checks++; if (cnt0 !== 16'd14) begin failures++; $display("FAIL burst_cnt got %0d want 14", cnt0); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; int lat; logic e;
    xfer(0, 1'b1, 32'h0, 32'h5A5A1234, 4'hF, rd, lat, e);
    xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, rd, lat, e);
    checks++; if (lat !== 1) begin failures++; $display("FAIL oor_latency got %0d want 1", lat); end
`ifdef WB_MEM_RESPONDER_ERR_EN
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got %b want 1", e); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_data got %h want 0", rd); end
`else
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL oor_err got %b want 0", e); end
    checks++; if (rd !== 32'h5A5A1234) begin failures++; $display("FAIL oor_data got %h want 5a5a1234", rd); end
`endif
    checks++; if (cnt0 !== 16'd16) begin failures++; $display("FAIL oor_cnt got %0d want 16", cnt0); end
  endtask

  task automatic test_reset_midcycle;
    logic [31:0] rd; int lat; logic e; logic seen;
    xfer(1, 1'b1, 32'h50, 32'h01020304, 4'hF, rd, lat, e);
    @(posedge clk); #1;
    adr = 32'h50; dat_w = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; cti = CTI_CLASSIC; set_req(1, 1'b1);
    seen = 1'b0;
    @(negedge clk); seen |= ack1 | err1;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk); seen |= ack1 | err1;
    @(posedge clk); #1; rst = 1'b0; set_req(1, 1'b0); we = 1'b0;
    repeat (5) begin @(negedge clk); seen |= ack1 | err1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got %b want 0", seen); end
    checks++; if (cnt1 !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt1 got %0d want 0", cnt1); end
    checks++; if (cnt0 !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt0 got %0d want 0", cnt0); end
    xfer(1, 1'b0, 32'h50, 32'h0, 4'hF, rd, lat, e);
    checks++; if (rd !== 32'h01020304) begin failures++; $display("FAIL rst_mid_mem got %h want 01020304", rd); end
    checks++; if (cnt1 !== 16'd1) begin failures++; $display("FAIL rst_mid_cnt_after got %0d want 1", cnt1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_byte_lanes();
    test_wrap_burst();
    test_out_of_range();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_mem_responder.md
# wb_mem_responder

Synthesizable Wishbone B3 slave that answers the far end of the interconnect: it terminates cycles issued through wb_mux/wb_arbiter with a word-addressed memory, programmable wait states and registered-feedback incrementing bursts. It is the slave model for the interconnect regression benches and the default memory target behind an interconnect port. It also exports a completed-beat counter so benches can check traffic without snooping the bus.

## Interface
- DW, 32: data width; byte lanes = DW/8.
- AW, 32: byte-address width.
- MEM_WORDS, 256: memory depth in DW-wide words; power of two.
- WAIT_STATES, 0: idle cycles inserted before every non-burst ack, 0..15.
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  AW  byte address; bits [log2(DW/8)-1:0] ignored.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  DW  read data, valid while wb_ack_o high.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  constant 0.
- beat_cnt_o  out  16  number of beats terminated (ack or err) since reset; wraps at 0xFFFF→0.

## Operation
- Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, beat_cnt_o=0, state IDLE, wait counter 0. Memory contents are not cleared.
- States: IDLE, WAIT, ACK, BURST.
- IDLE: on cyc&stb, latch address/cti/bte; go to ACK if WAIT_STATES==0, else load counter=WAIT_STATES and go to WAIT.
- WAIT: decrement counter each cycle; at 1 go to ACK. If cyc or stb drops, return to IDLE with no termination.
- ACK: one-cycle ack (or err); writes commit in this cycle from wb_dat_i under wb_sel_i; reads present mem[word] on wb_dat_o. Next: BURST if cti==010, cyc&stb still high and WAIT_STATES==0; otherwise IDLE.
- BURST: ack held high each cycle; address advanced internally by one word per beat (linear: +1 word; wrapN: low log2(N) word bits increment modulo N, upper bits fixed). Burst ends (ack low next cycle, go IDLE) on the beat where master presents cti==111, or immediately when cyc or stb drops, or when cti changes to 000.
- WAIT_STATES>0: bursts degrade to classic; each beat pays full wait.
- Address decode: word index = adr >> log2(DW/8). Out-of-range behaviour per Configuration.
- beat_cnt_o increments once per cycle in which ack or err is high.

## Timing
- Classic latency: request sampled cycle N, ack in cycle N+1+WAIT_STATES, low in N+2+WAIT_STATES.
- Back-to-back classic: minimum 2 cycles per beat (ack must drop between cycles).
- Burst at WAIT_STATES==0: first ack N+1, then one beat per cycle.
- ack and err are mutually exclusive and never high while cyc is low.
- Reset mid-cycle: ack/err low the cycle after wb_rst_i is sampled; pending write not committed.

## Configuration
- WB_MEM_RESPONDER_ERR_EN defined: word index >= MEM_WORDS terminates with wb_err_o instead of ack; no write, wb_dat_o=0; a burst crossing the limit ends with err on the offending beat.
- Undefined: index taken modulo MEM_WORDS; wb_err_o constant 0.

## Structure
- Package wb_responder_pkg: CTI_CLASSIC/CTI_INC/CTI_EOB and BTE_LINEAR/WRAP4/WRAP8/WRAP16 constants, state enum.
- Sub-module wb_burst_addr_gen: combinational next-word-address from current address and bte; reused by other burst-capable slaves.
- Memory array inline, byte-lane writes.

## Test plan
- Write 0xDEADBEEF sel=1111 to 0x10, WAIT_STATES=0 -> ack one cycle after request; read 0x10 -> 0xDEADBEEF; beat_cnt_o=2.
- WAIT_STATES=3, read 0x20 -> ack exactly 4 cycles after stb; drop stb at cycle 2 -> no ack, beat_cnt_o unchanged.
- Write 0xAABBCCDD to 0x40, then write 0x11223344 sel=0101 -> read 0xAA22CC44.
- wrap4 read burst from 0x38, four beats, last cti=111 -> data from 0x38,0x3C,0x30,0x34 on consecutive cycles; ack low cycle after last beat.
- With WB_MEM_RESPONDER_ERR_EN, read 0x400 (MEM_WORDS=256) -> err one cycle after request, ack 0; without macro -> ack with mem[0] data.
- Assert wb_rst_i during WAIT of a write to 0x50 -> no ack/err, beat_cnt_o=0, mem[0x50] unchanged.
